// File: rtl/ram_pkg.sv
// Shared definitions for the RAM controller: FSM state encodings and default geometry.
package ram_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ADDR  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/ram_core.sv
// Simple dual-port storage: one write port and one registered read port.
// The array itself is never reset; only the read-data register is.
module ram_core #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [ADDR-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [ADDR-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // The read samples the array before this edge's write lands, giving read-before-write.
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem[i_raddr];
  end

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// RAM controller: passes reads/writes to ram_core while idle and runs a
// zeroing sweep over every address after reset or on a clear request.
module ram_ctrl
  import ram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wen,
  input  logic [ADDR-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ren,
  input  logic [ADDR-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  input  logic             i_clr,
  output logic             o_busy
);

  localparam logic [ADDR:0] LAST_ADDR = {1'b0, {ADDR{1'b1}}};

  state_e          state_d, state_q;
  logic [ADDR:0]   cnt_d, cnt_q;
  logic            rvalid_d, rvalid_q;

  logic            core_we;
  logic [ADDR-1:0] core_waddr;
  logic [WIDTH-1:0] core_wdata;
  logic            core_re;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rvalid_d   = 1'b0;
    core_we    = 1'b0;
    core_waddr = i_waddr;
    core_wdata = i_wdata;
    core_re    = 1'b0;
    if (!i_rst) begin
      case (state_q)
        ST_IDLE: begin
          core_we  = i_wen;
          core_re  = i_ren;
          rvalid_d = i_ren;
          if (i_clr) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
        ST_CLEAR: begin
          // Requests are ignored; the counter's extra bit keeps it from wrapping into a re-clear.
          core_we    = 1'b1;
          core_waddr = cnt_q[ADDR-1:0];
          core_wdata = '0;
          cnt_d      = cnt_q + (ADDR+1)'(1);
          if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  ram_core #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR)
  ) u_core (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (core_we),
    .i_waddr (core_waddr),
    .i_wdata (core_wdata),
    .i_re    (core_re),
    .i_raddr (i_raddr),
    .o_rdata (o_rdata)
  );

  assign o_rvalid = rvalid_q;
  assign o_busy   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a behavioural model.
module tb_ram_ctrl;

  localparam int WIDTH = 8;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_wen;
  logic [ADDR-1:0]  i_waddr;
  logic [WIDTH-1:0] i_wdata;
  logic             i_ren;
  logic [ADDR-1:0]  i_raddr;
  logic [WIDTH-1:0] o_rdata;
  logic             o_rvalid;
  logic             i_clr;
  logic             o_busy;

  int check_count = 0;
  int pass_count  = 0;

  // Behavioural model: memory contents, remaining busy cycles, expected read outputs.
  logic [WIDTH-1:0] model_mem [DEPTH];
  int               busy_left = 0;
  logic             exp_rvalid = 1'b0;
  logic [WIDTH-1:0] exp_rdata = '0;
  bit               check_en = 1'b0;

  ram_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wen    (i_wen),
    .i_waddr  (i_waddr),
    .i_wdata  (i_wdata),
    .i_ren    (i_ren),
    .i_raddr  (i_raddr),
    .o_rdata  (o_rdata),
    .o_rvalid (o_rvalid),
    .i_clr    (i_clr),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Model update: a clear wipes the whole memory at once since nothing can observe it mid-sweep.
  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
      busy_left  = DEPTH;
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
      check_en   = 1'b1;
    end else if (busy_left > 0) begin
      busy_left--;
      exp_rvalid = 1'b0;
    end else begin
      exp_rvalid = i_ren;
      if (i_ren) exp_rdata = model_mem[i_raddr];
      if (i_wen) model_mem[i_waddr] = i_wdata;
      if (i_clr) begin
        for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
        busy_left = DEPTH;
      end
    end
  end

  always @(negedge i_clk) begin
    if (check_en) begin
      checkOutput("model_busy",   32'(o_busy),   32'(busy_left > 0));
      checkOutput("model_rvalid", 32'(o_rvalid), 32'(exp_rvalid));
      checkOutput("model_rdata",  32'(o_rdata),  32'(exp_rdata));
    end
  end

  // Drives one cycle of inputs, then returns just after the edge that consumed them.
  task automatic applyStimulus(input logic rst, input logic clr, input logic wen,
                               input logic [ADDR-1:0] waddr, input logic [WIDTH-1:0] wdata,
                               input logic ren, input logic [ADDR-1:0] raddr);
    @(negedge i_clk);
    i_rst = rst; i_clr = clr; i_wen = wen; i_waddr = waddr;
    i_wdata = wdata; i_ren = ren; i_raddr = raddr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic randomCycle(input int clr_pct, input int rst_pct);
    applyStimulus(($urandom_range(999) < rst_pct), ($urandom_range(99) < clr_pct),
                  1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
  endtask

  // Counts busy cycles starting with the current one; optionally hammers inputs meanwhile.
  task automatic countBusy(input bit noisy, output int n, output int pulses);
    n = 0; pulses = 0;
    while (o_busy && n < 40) begin
      n++;
      if (o_rvalid) pulses++;
      if (noisy) applyStimulus(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
      else idleCycle();
    end
    if (o_rvalid) pulses++;
  endtask

  task automatic readAll(input logic [WIDTH-1:0] expected, input string name);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'(a));
      checkOutput({name, "_rvalid"}, 32'(o_rvalid), 32'd1);
      checkOutput({name, "_rdata"},  32'(o_rdata),  32'(expected));
    end
  endtask

  initial begin
    int n, pulses;
    i_rst = 1'b1; i_clr = 1'b0; i_wen = 1'b0; i_waddr = '0;
    i_wdata = '0; i_ren = 1'b0; i_raddr = '0;

    // Reset for one cycle, then the sweep must keep busy high for 16 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("rst_busy",   32'(o_busy),   32'd1);
    checkOutput("rst_rvalid", 32'(o_rvalid), 32'd0);
    checkOutput("rst_rdata",  32'(o_rdata),  32'd0);
    countBusy(1'b0, n, pulses);
    checkOutput("rst_busy_len", 32'(n), 32'd16);
    readAll(8'h00, "rst_read");

    // Back-to-back reads after two writes.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd3,  8'hA5, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd12, 8'h5A, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd3);
    checkOutput("b2b_rvalid0", 32'(o_rvalid), 32'd1);
    checkOutput("b2b_rdata0",  32'(o_rdata),  32'hA5);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd12);
    checkOutput("b2b_rvalid1", 32'(o_rvalid), 32'd1);
    checkOutput("b2b_rdata1",  32'(o_rdata),  32'h5A);
    idleCycle();
    checkOutput("hold_rvalid", 32'(o_rvalid), 32'd0);
    checkOutput("hold_rdata",  32'(o_rdata),  32'h5A);

    // Read-before-write on the same address, and write+read to different addresses.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 8'h11, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 8'h77, 1'b1, 4'd5);
    checkOutput("rbw_old", 32'(o_rdata), 32'h11);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd6, 8'h66, 1'b1, 4'd5);
    checkOutput("rbw_new", 32'(o_rdata), 32'h77);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd6);
    checkOutput("diff_addr", 32'(o_rdata), 32'h66);

    // Fill with FF, clear while hammering inputs during the sweep.
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, 1'b0, 1'b1, 4'(a), 8'hFF, 1'b0, '0);
    readAll(8'hFF, "fill_read");
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    countBusy(1'b1, n, pulses);
    checkOutput("clr_busy_len", 32'(n), 32'd16);
    checkOutput("clr_no_rvalid", 32'(pulses), 32'd0);
    readAll(8'h00, "clr_read");

    // Reset at sweep cycle 7 restarts the full sweep.
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int c = 0; c < 7; c++) idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    countBusy(1'b0, n, pulses);
    checkOutput("midrst_busy_len", 32'(n), 32'd16);

    // Read accepted in the clear-request cycle still returns pre-clear data.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd9, 8'h3C, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 4'd9);
    checkOutput("clrrd_rvalid", 32'(o_rvalid), 32'd1);
    checkOutput("clrrd_rdata",  32'(o_rdata),  32'h3C);
    checkOutput("clrrd_busy",   32'(o_busy),   32'd1);
    countBusy(1'b0, n, pulses);
    checkOutput("clrrd_busy_len", 32'(n), 32'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 4'd9);
    checkOutput("clrrd_after", 32'(o_rdata), 32'h00);

    // Randomized traffic, occasional clears and rare resets.
    for (int c = 0; c < 600; c++) randomCycle(3, 5);
    for (int c = 0; c < 40; c++) idleCycle();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR, default 4, address width; DEPTH = 2^ADDR words.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_wen  input  1  write request, sampled each cycle.
REQ-006 SHALL have port i_waddr  input  ADDR  write address.
REQ-007 SHALL have port i_wdata  input  WIDTH  write data.
REQ-008 SHALL have port i_ren  input  1  read request, sampled each cycle.
REQ-009 SHALL have port i_raddr  input  ADDR  read address.
REQ-010 SHALL have port o_rdata  output  WIDTH  registered read data.
REQ-011 SHALL have port o_rvalid  output  1  o_rdata valid this cycle, one-cycle pulse per accepted read.
REQ-012 SHALL have port i_clr  input  1  request to zero the whole memory.
REQ-013 SHALL have port o_busy  output  1  clear sweep in progress; requests ignored.

Function
REQ-014 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-015 In IDLE, i_wen=1 SHALL write i_wdata to i_waddr at the same edge.
REQ-016 In IDLE, i_ren=1 SHALL present mem[i_raddr] on o_rdata with o_rvalid=1 exactly one cycle later (latency 1).
REQ-017 When i_ren=0, or in CLEAR, o_rvalid SHALL be 0 next cycle and o_rdata SHALL hold its last value.
REQ-018 Same-cycle read and write to the same address SHALL return the old (pre-write) data (read-before-write).
REQ-019 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-020 i_clr=1 in IDLE SHALL move FSM to CLEAR with sweep counter 0; o_busy=1 from the next cycle.
REQ-021 In CLEAR, the block SHALL write 0 to address = counter each cycle, increment the counter, and return to IDLE after address DEPTH-1 is written.
REQ-022 o_busy SHALL be high for exactly DEPTH cycles per sweep and low in the cycle the FSM re-enters IDLE.
REQ-023 In CLEAR, i_wen, i_ren and i_clr SHALL be ignored (no write, no o_rvalid, no restart).
REQ-024 Sweep counter SHALL be ADDR+1 bits wide or terminate on DEPTH-1 compare; it SHALL NOT wrap and re-clear.
REQ-025 A read accepted in the cycle before entering CLEAR SHALL still produce its o_rvalid pulse.

Reset
REQ-026 i_rst=1 SHALL set o_rdata=0, o_rvalid=0, counter=0, state=CLEAR, o_busy=1 at the next edge.
REQ-027 After i_rst falls, the block SHALL complete a full DEPTH-cycle zero sweep before accepting requests, so memory reads 0 everywhere after reset.
REQ-028 i_rst asserted mid-sweep or mid-operation SHALL restart the sweep from address 0.
REQ-029 i_rst SHALL take priority over i_clr, i_wen and i_ren.

Structure
REQ-030 FSM state encodings (IDLE, CLEAR) SHALL reside in a shared package/header ram_pkg, with default WIDTH/ADDR constants.
REQ-031 Storage SHALL be a sub-module ram_core (one write port, one registered read port, no reset on the array) instantiated once by ram_ctrl.
REQ-032 No bidirectional/tri-state ports SHALL be used; read and write data paths are separate.

Verification (WIDTH=8, ADDR=4)
REQ-033 Reset 1 cycle then release -> o_busy=1 for 16 cycles, then 0; read of addrs 0..15 returns 8'h00 each with o_rvalid one cycle after i_ren.
REQ-034 Write 8'hA5 to 3, 8'h5A to 12, then read 3,12 back-to-back -> o_rdata 8'hA5 then 8'h5A, o_rvalid high two consecutive cycles.
REQ-035 Same cycle write 8'h77 to 5 and read 5 (mem[5]=8'h11) -> o_rdata 8'h11; next read of 5 -> 8'h77.
REQ-036 Fill all 16 addrs with 8'hFF, pulse i_clr, drive i_wen/i_ren/i_clr during busy -> no o_rvalid, busy exactly 16 cycles, all addrs then read 8'h00.
REQ-037 Assert i_rst at sweep cycle 7 -> sweep restarts at addr 0, o_busy stays high 16 cycles after i_rst release.
REQ-038 Read at addr 9 in the same cycle i_clr is asserted -> o_rvalid=1 with pre-clear data next cycle, then o_busy for 16 cycles.
